// File: rtl/lcd_frame_reader.sv
// lcd_frame_reader
//   Display-side consumer of the SDRAM controller read FIFO. Generates LCD
//   timing (HSYNC_N / VSYNC_N / DE) from free-running h/v counters and pops one
//   RGB565 word per active pixel while running. Each vertical blank it re-arms
//   the read port: RD_LOAD clears the FIFO and reloads the start address of the
//   frame buffer selected by FB_SEL.
//
// Ports
//   CLK, RESET_N       pixel clock, asynchronous active-low reset
//   ENABLE             1 = fetch and display, 0 = blank output and no reads
//   FB_SEL             frame buffer select, sampled on entry to LOAD
//   RD / RD_DATA       FIFO pop request / FIFO q (valid the cycle after RD)
//   RD_EMPTY, RD_USE   FIFO empty flag / FIFO fill level
//   RD_LOAD            read-port reload and FIFO clear
//   RD_ADDR            start address of the selected buffer
//   RD_MAX_ADDR        RD_ADDR + H_ACTIVE*V_ACTIVE
//   RD_LENGTH          burst length
//   LCD_RGB, LCD_DE    pixel data / data enable (2 CLK after counter position)
//   LCD_HSYNC_N/VSYNC_N sync outputs, active low, same 2 CLK delay
//   FRAME_START        1-cycle pulse while hcnt=0, vcnt=0
//   UNDERRUN           sticky, cleared on LOAD entry
module lcd_frame_reader #(
    parameter int          H_ACTIVE    = 800,
    parameter int          H_FP        = 210,
    parameter int          H_SYNC      = 20,
    parameter int          H_BP        = 26,
    parameter int          V_ACTIVE    = 480,
    parameter int          V_FP        = 22,
    parameter int          V_SYNC      = 10,
    parameter int          V_BP        = 13,
    parameter logic [21:0] FB0_BASE    = 22'h000000,
    parameter logic [21:0] FB1_BASE    = 22'h100000,
    parameter int          BURST_LEN   = 128,
    parameter int          PREFILL     = 256,
    parameter int          LOAD_CYCLES = 4,
    parameter logic [15:0] UNDER_COLOR = 16'h0000
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        ENABLE,
    input  logic        FB_SEL,
    output logic        RD,
    input  logic [15:0] RD_DATA,
    input  logic        RD_EMPTY,
    input  logic [15:0] RD_USE,
    output logic        RD_LOAD,
    output logic [21:0] RD_ADDR,
    output logic [21:0] RD_MAX_ADDR,
    output logic [8:0]  RD_LENGTH,
    output logic [15:0] LCD_RGB,
    output logic        LCD_DE,
    output logic        LCD_HSYNC_N,
    output logic        LCD_VSYNC_N,
    output logic        FRAME_START,
    output logic        UNDERRUN
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int LW      = $clog2(LOAD_CYCLES + 1);
    localparam logic [21:0] FRAME_WORDS = 22'(H_ACTIVE * V_ACTIVE);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_FILL = 2'd2;
    localparam logic [1:0] S_RUN  = 2'd3;

    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic [1:0]    state;
    logic [LW-1:0] load_cnt;

    logic h_act, v_act, hs, vs;
    logic h_end, v_end, frame_end, reload_pt;
    logic load_entry, fill_miss;

    // stage 1 of the output pipeline
    logic need1, popped1, de1, hs1_n, vs1_n;

    assign h_act     = hcnt < HW'(H_ACTIVE);
    assign v_act     = vcnt < VW'(V_ACTIVE);
    assign hs        = (hcnt >= HW'(H_ACTIVE + H_FP)) && (hcnt < HW'(H_ACTIVE + H_FP + H_SYNC));
    assign vs        = (vcnt >= VW'(V_ACTIVE + V_FP)) && (vcnt < VW'(V_ACTIVE + V_FP + V_SYNC));
    assign h_end     = hcnt == HW'(H_TOTAL - 1);
    assign v_end     = vcnt == VW'(V_TOTAL - 1);
    assign frame_end = h_end && v_end;
    assign reload_pt = (vcnt == VW'(V_ACTIVE)) && (hcnt == '0);

    // LOAD is entered from IDLE or RUN at the start of vertical blank
    assign load_entry = reload_pt && ENABLE && ((state == S_IDLE) || (state == S_RUN));
    assign fill_miss  = (state == S_FILL) && frame_end && (RD_USE < 16'(PREFILL));

    assign RD        = (state == S_RUN) && h_act && v_act && !RD_EMPTY;
    assign RD_LOAD   = state == S_LOAD;
    assign RD_LENGTH = 9'(BURST_LEN);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (h_end) begin
            hcnt <= '0;
            vcnt <= v_end ? '0 : vcnt + 1'b1;
        end else begin
            hcnt <= hcnt + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= S_IDLE;
            load_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: if (load_entry) state <= S_LOAD;
                S_LOAD: begin
                    if (load_cnt == LW'(LOAD_CYCLES - 1)) begin
                        load_cnt <= '0;
                        state    <= S_FILL;
                    end else begin
                        load_cnt <= load_cnt + 1'b1;
                    end
                end
                S_FILL: if (frame_end && (RD_USE >= 16'(PREFILL))) state <= S_RUN;
                default: begin
                    if (reload_pt) state <= ENABLE ? S_LOAD : S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            RD_ADDR     <= FB0_BASE;
            RD_MAX_ADDR <= FB0_BASE + FRAME_WORDS;
        end else if (load_entry) begin
            RD_ADDR     <= FB_SEL ? FB1_BASE : FB0_BASE;
            RD_MAX_ADDR <= (FB_SEL ? FB1_BASE : FB0_BASE) + FRAME_WORDS;
        end
    end

    // The clear on LOAD entry cannot coincide with a missed pixel: the pipeline
    // then holds horizontal blank positions of the previous line.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            UNDERRUN <= 1'b0;
        end else if (load_entry) begin
            UNDERRUN <= 1'b0;
        end else if ((need1 && !popped1) || fill_miss) begin
            UNDERRUN <= 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            need1       <= 1'b0;
            popped1     <= 1'b0;
            de1         <= 1'b0;
            hs1_n       <= 1'b1;
            vs1_n       <= 1'b1;
            LCD_RGB     <= UNDER_COLOR;
            LCD_DE      <= 1'b0;
            LCD_HSYNC_N <= 1'b1;
            LCD_VSYNC_N <= 1'b1;
            FRAME_START <= 1'b0;
        end else begin
            need1       <= (state == S_RUN) && h_act && v_act;
            popped1     <= RD;
            de1         <= h_act && v_act;
            hs1_n       <= !hs;
            vs1_n       <= !vs;
            LCD_RGB     <= popped1 ? RD_DATA : UNDER_COLOR;
            LCD_DE      <= de1;
            LCD_HSYNC_N <= hs1_n;
            LCD_VSYNC_N <= vs1_n;
            // registered so the pulse is high while the counters sit at 0,0
            FRAME_START <= frame_end;
        end
    end

endmodule

// File: tb/tb_lcd_frame_reader.sv
module tb_lcd_frame_reader;

    // Reduced raster so whole frames simulate quickly
    localparam int HA = 8, HF = 3, HS = 2, HB = 2, HT = HA + HF + HS + HB;
    localparam int VA = 4, VF = 2, VS = 1, VB = 1, VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;
    localparam int NW = HA * VA;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        ENABLE = 1'b0;
    logic        FB_SEL = 1'b0;
    logic        RD;
    logic [15:0] RD_DATA = 16'h0000;
    logic        RD_EMPTY;
    logic [15:0] RD_USE;
    logic        RD_LOAD;
    logic [21:0] RD_ADDR;
    logic [21:0] RD_MAX_ADDR;
    logic [8:0]  RD_LENGTH;
    logic [15:0] LCD_RGB;
    logic        LCD_DE;
    logic        LCD_HSYNC_N;
    logic        LCD_VSYNC_N;
    logic        FRAME_START;
    logic        UNDERRUN;

    int n_assert = 0;
    int n_fail   = 0;

    lcd_frame_reader #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .FB0_BASE(22'h000000), .FB1_BASE(22'h100000),
        .BURST_LEN(128), .PREFILL(8), .LOAD_CYCLES(4), .UNDER_COLOR(16'h0000)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N), .ENABLE(ENABLE), .FB_SEL(FB_SEL),
        .RD(RD), .RD_DATA(RD_DATA), .RD_EMPTY(RD_EMPTY), .RD_USE(RD_USE),
        .RD_LOAD(RD_LOAD), .RD_ADDR(RD_ADDR), .RD_MAX_ADDR(RD_MAX_ADDR),
        .RD_LENGTH(RD_LENGTH), .LCD_RGB(LCD_RGB), .LCD_DE(LCD_DE),
        .LCD_HSYNC_N(LCD_HSYNC_N), .LCD_VSYNC_N(LCD_VSYNC_N),
        .FRAME_START(FRAME_START), .UNDERRUN(UNDERRUN)
    );

    always #5 CLK = ~CLK;

    // Reference raster position: cycles since reset release
    int p = 0;
    int cur_h, cur_v;
    always @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) p <= 0;
        else          p <= p + 1;
    end
    assign cur_h = p % HT;
    assign cur_v = (p / HT) % VT;

    // Frame buffer contents as seen through the FIFO
    function automatic logic [15:0] word(input logic [21:0] a);
        return a[15:0] ^ a[21:6] ^ 16'h5A3C;
    endfunction

    // FIFO model: cleared by RD_LOAD, refilled at one word per clock up to
    // one frame's worth, capped at fill_limit words held.
    int          fcount    = 0;
    int          pushed_n  = 0;
    int          popped_n  = 0;
    int          fill_limit = 64;
    logic [21:0] fbase     = 22'h0;
    bit          gap_en    = 1'b0;
    logic        push, gap_now;

    assign push     = (pushed_n < NW) && (fcount < fill_limit);
    assign gap_now  = gap_en && (cur_v == 2) && (cur_h >= 2) && (cur_h < 7);
    assign RD_EMPTY = (fcount == 0) || gap_now;
    assign RD_USE   = 16'(fcount);

    always @(posedge CLK) begin
        if (RD_LOAD) begin
            fcount   <= 0;
            pushed_n <= 0;
            popped_n <= 0;
            fbase    <= RD_ADDR;
        end else begin
            if (RD) begin
                RD_DATA  <= word(fbase + 22'(popped_n));
                popped_n <= popped_n + 1;
            end
            if (push) pushed_n <= pushed_n + 1;
            fcount <= fcount + (push ? 1 : 0) - (RD ? 1 : 0);
        end
    end

    function automatic bit exp_hs_n(input int q);
        int h;
        if (q < 0) return 1'b1;
        h = q % HT;
        return !((h >= HA + HF) && (h < HA + HF + HS));
    endfunction

    function automatic bit exp_vs_n(input int q);
        int v;
        if (q < 0) return 1'b1;
        v = (q / HT) % VT;
        return !((v >= VA + VF) && (v < VA + VF + VS));
    endfunction

    function automatic bit exp_de(input int q);
        if (q < 0) return 1'b0;
        return ((q % HT) < HA) && (((q / HT) % VT) < VA);
    endfunction

    task automatic test_reset();
        RESET_N = 1'b0;
        ENABLE  = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        n_assert++; if (LCD_DE !== 1'b0)          begin n_fail++; $display("FAIL reset_de got %b exp 0", LCD_DE); end
        n_assert++; if (LCD_HSYNC_N !== 1'b1)     begin n_fail++; $display("FAIL reset_hsync got %b exp 1", LCD_HSYNC_N); end
        n_assert++; if (LCD_VSYNC_N !== 1'b1)     begin n_fail++; $display("FAIL reset_vsync got %b exp 1", LCD_VSYNC_N); end
        n_assert++; if (LCD_RGB !== 16'h0000)     begin n_fail++; $display("FAIL reset_rgb got %h exp 0000", LCD_RGB); end
        n_assert++; if (RD !== 1'b0)              begin n_fail++; $display("FAIL reset_rd got %b exp 0", RD); end
        n_assert++; if (RD_LOAD !== 1'b0)         begin n_fail++; $display("FAIL reset_rd_load got %b exp 0", RD_LOAD); end
        n_assert++; if (FRAME_START !== 1'b0)     begin n_fail++; $display("FAIL reset_frame_start got %b exp 0", FRAME_START); end
        n_assert++; if (UNDERRUN !== 1'b0)        begin n_fail++; $display("FAIL reset_underrun got %b exp 0", UNDERRUN); end
        n_assert++; if (RD_ADDR !== 22'h000000)   begin n_fail++; $display("FAIL reset_rd_addr got %h exp 000000", RD_ADDR); end
        n_assert++; if (RD_MAX_ADDR !== 22'd32)   begin n_fail++; $display("FAIL reset_rd_max got %h exp 000020", RD_MAX_ADDR); end
        n_assert++; if (RD_LENGTH !== 9'd128)     begin n_fail++; $display("FAIL reset_rd_length got %0d exp 128", RD_LENGTH); end
        RESET_N = 1'b1;
    endtask

    // ENABLE=0 for two frames: sync/DE timing only, no reads, blank data
    task automatic test_blank();
        int q;
        for (int i = 0; i < 2 * FT; i++) begin
            @(negedge CLK);
            q = p - 2;
            n_assert++; if (LCD_HSYNC_N !== exp_hs_n(q)) begin n_fail++; $display("FAIL blank_hsync p=%0d got %b exp %b", p, LCD_HSYNC_N, exp_hs_n(q)); end
            n_assert++; if (LCD_VSYNC_N !== exp_vs_n(q)) begin n_fail++; $display("FAIL blank_vsync p=%0d got %b exp %b", p, LCD_VSYNC_N, exp_vs_n(q)); end
            n_assert++; if (LCD_DE !== exp_de(q))        begin n_fail++; $display("FAIL blank_de p=%0d got %b exp %b", p, LCD_DE, exp_de(q)); end
            n_assert++; if (RD !== 1'b0)                 begin n_fail++; $display("FAIL blank_rd p=%0d got %b exp 0", p, RD); end
            n_assert++; if (LCD_RGB !== 16'h0000)        begin n_fail++; $display("FAIL blank_rgb p=%0d got %h exp 0000", p, LCD_RGB); end
            n_assert++; if (FRAME_START !== (p > 0 && p % FT == 0))
                begin n_fail++; $display("FAIL blank_frame_start p=%0d got %b", p, FRAME_START); end
        end
    endtask

    // Waits for the next reload and checks its position, width and addresses
    task automatic test_load(input logic [21:0] base);
        bit found = 1'b0;
        int width = 0;
        for (int i = 0; i < 3 * FT && !found; i++) begin
            @(negedge CLK);
            if (RD_LOAD === 1'b1) found = 1'b1;
        end
        n_assert++;
        if (!found) begin
            n_fail++; $display("FAIL load_timeout got no RD_LOAD exp pulse within %0d clk", 3 * FT);
        end else begin
            if (cur_v != VA || cur_h != 1) begin
                n_fail++; $display("FAIL load_position got v=%0d h=%0d exp v=%0d h=1", cur_v, cur_h, VA);
            end
            n_assert++; if (RD_ADDR !== base)                begin n_fail++; $display("FAIL load_rd_addr got %h exp %h", RD_ADDR, base); end
            n_assert++; if (RD_MAX_ADDR !== base + 22'(NW)) begin n_fail++; $display("FAIL load_rd_max got %h exp %h", RD_MAX_ADDR, base + 22'(NW)); end
            n_assert++; if (RD_LENGTH !== 9'd128)            begin n_fail++; $display("FAIL load_rd_length got %0d exp 128", RD_LENGTH); end
            while (RD_LOAD === 1'b1 && width < 10) begin
                width++;
                @(negedge CLK);
            end
            n_assert++; if (width != 4) begin n_fail++; $display("FAIL load_width got %0d exp 4", width); end
        end
    endtask

    // Checks one running frame: DE timing, pixel sequence from base (with an
    // optional 5-pixel empty window on line 2), UNDERRUN before and after LOAD.
    task automatic check_frame(input logic [21:0] base, input bit gap,
                               input bit exp_under, input string name);
        bit found = 1'b0;
        int q, hq, vq, idx, npix;
        logic [15:0] exp_rgb;
        gap_en = gap;
        for (int i = 0; i < 2 * FT && !found; i++) begin
            @(negedge CLK);
            if (p % FT == 0) found = 1'b1;
        end
        if (!found) begin
            n_assert++; n_fail++;
            $display("FAIL %s_frame_timeout got no frame start exp one within %0d clk", name, 2 * FT);
            return;
        end
        idx = 0; npix = 0;
        for (int i = 0; i < 63; i++) begin
            if (i > 0) @(negedge CLK);
            q = p - 2; hq = q % HT; vq = (q / HT) % VT;
            n_assert++; if (LCD_DE !== exp_de(q)) begin n_fail++; $display("FAIL %s_de p=%0d got %b exp %b", name, p, LCD_DE, exp_de(q)); end
            if (exp_de(q)) begin
                npix++;
                if (gap && vq == 2 && hq >= 2 && hq < 7) exp_rgb = 16'h0000;
                else begin exp_rgb = word(base + 22'(idx)); idx++; end
                n_assert++; if (LCD_RGB !== exp_rgb) begin n_fail++; $display("FAIL %s_rgb v=%0d h=%0d got %h exp %h", name, vq, hq, LCD_RGB, exp_rgb); end
            end
            if (p % FT == VA * HT) begin
                n_assert++; if (UNDERRUN !== exp_under) begin n_fail++; $display("FAIL %s_underrun got %b exp %b", name, UNDERRUN, exp_under); end
            end
        end
        n_assert++; if (npix != NW) begin n_fail++; $display("FAIL %s_pixel_count got %0d exp %0d", name, npix, NW); end
        n_assert++; if (UNDERRUN !== 1'b0) begin n_fail++; $display("FAIL %s_underrun_clear got %b exp 0", name, UNDERRUN); end
        gap_en = 1'b0;
    endtask

    task automatic test_ramp();
        ENABLE = 1'b1;
        FB_SEL = 1'b1;
        test_load(22'h100000);
        check_frame(22'h100000, 1'b0, 1'b0, "ramp");
    endtask

    // FB_SEL changed outside LOAD entry must not move the address
    task automatic test_fb_sel_ignored();
        bit found = 1'b0;
        FB_SEL = 1'b0;
        for (int i = 0; i < 2 * FT && !found; i++) begin
            @(negedge CLK);
            if (cur_v == 2) found = 1'b1;
        end
        n_assert++;
        if (!found) begin n_fail++; $display("FAIL fbsel_timeout got no line 2 exp one within %0d clk", 2 * FT); end
        else if (RD_ADDR !== 22'h100000) begin n_fail++; $display("FAIL fbsel_rd_addr got %h exp 100000", RD_ADDR); end
        FB_SEL = 1'b1;
    endtask

    task automatic test_underrun();
        check_frame(22'h100000, 1'b1, 1'b1, "underrun");
        check_frame(22'h100000, 1'b0, 1'b0, "recover");
    endtask

    // FIFO capped below PREFILL: FSM must stay in FILL and never read
    task automatic test_fill_stall();
        bit found = 1'b0;
        fill_limit = 4;
        for (int i = 0; i < 2 * FT && !found; i++) begin
            @(negedge CLK);
            if (p % FT == 0) found = 1'b1;
        end
        n_assert++;
        if (!found) begin n_fail++; $display("FAIL stall_timeout got no frame start exp one within %0d clk", 2 * FT); return; end
        if (UNDERRUN !== 1'b1) begin n_fail++; $display("FAIL stall_underrun got %b exp 1", UNDERRUN); end
        for (int i = 0; i < FT; i++) begin
            if (i > 0) @(negedge CLK);
            n_assert++; if (RD !== 1'b0)          begin n_fail++; $display("FAIL stall_rd p=%0d got %b exp 0", p, RD); end
            n_assert++; if (RD_LOAD !== 1'b0)     begin n_fail++; $display("FAIL stall_rd_load p=%0d got %b exp 0", p, RD_LOAD); end
            n_assert++; if (LCD_RGB !== 16'h0000) begin n_fail++; $display("FAIL stall_rgb p=%0d got %h exp 0000", p, LCD_RGB); end
            n_assert++; if (LCD_DE !== exp_de(p - 2)) begin n_fail++; $display("FAIL stall_de p=%0d got %b exp %b", p, LCD_DE, exp_de(p - 2)); end
        end
        n_assert++; if (UNDERRUN !== 1'b1) begin n_fail++; $display("FAIL stall_underrun_hold got %b exp 1", UNDERRUN); end
    endtask

    // Reset pulse during an active line of a running frame
    task automatic test_reset_mid();
        bit found = 1'b0;
        fill_limit = 64;
        FB_SEL     = 1'b0;
        for (int i = 0; i < 4 * FT && !found; i++) begin
            @(negedge CLK);
            if (RD === 1'b1 && cur_v == 1 && cur_h == 3) found = 1'b1;
        end
        n_assert++;
        if (!found) begin n_fail++; $display("FAIL rstmid_timeout got no RUN line exp one within %0d clk", 4 * FT); return; end
        RESET_N = 1'b0;
        #1;
        n_assert++; if (RD !== 1'b0)            begin n_fail++; $display("FAIL rstmid_rd got %b exp 0", RD); end
        n_assert++; if (RD_LOAD !== 1'b0)       begin n_fail++; $display("FAIL rstmid_rd_load got %b exp 0", RD_LOAD); end
        n_assert++; if (LCD_DE !== 1'b0)        begin n_fail++; $display("FAIL rstmid_de got %b exp 0", LCD_DE); end
        n_assert++; if (LCD_HSYNC_N !== 1'b1)   begin n_fail++; $display("FAIL rstmid_hsync got %b exp 1", LCD_HSYNC_N); end
        n_assert++; if (LCD_VSYNC_N !== 1'b1)   begin n_fail++; $display("FAIL rstmid_vsync got %b exp 1", LCD_VSYNC_N); end
        n_assert++; if (LCD_RGB !== 16'h0000)   begin n_fail++; $display("FAIL rstmid_rgb got %h exp 0000", LCD_RGB); end
        n_assert++; if (RD_ADDR !== 22'h000000) begin n_fail++; $display("FAIL rstmid_rd_addr got %h exp 000000", RD_ADDR); end
        n_assert++; if (RD_MAX_ADDR !== 22'd32) begin n_fail++; $display("FAIL rstmid_rd_max got %h exp 000020", RD_MAX_ADDR); end
        n_assert++; if (UNDERRUN !== 1'b0)      begin n_fail++; $display("FAIL rstmid_underrun got %b exp 0", UNDERRUN); end
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        n_assert++; if (LCD_RGB !== 16'h0000 || LCD_DE !== 1'b0 || RD !== 1'b0)
            begin n_fail++; $display("FAIL rstmid_hold got rgb=%h de=%b rd=%b exp 0000/0/0", LCD_RGB, LCD_DE, RD); end
        RESET_N = 1'b1;
        test_load(22'h000000);
        check_frame(22'h000000, 1'b0, 1'b0, "restart");
    endtask

    initial begin
        test_reset();
        test_blank();
        test_ramp();
        test_fb_sel_ignored();
        test_underrun();
        test_fill_stall();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
